writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter LEN_REGNO, default 4, register-number width.
REQ-002 Parameter LEN_REG, default 32, register data width.
REQ-003 Parameter NUM_REGS, default 16, number of general registers (2**LEN_REGNO).
REQ-004 Parameter NUM_REQ, default 3, number of writeback requesters (0=ALU, 1=MEM, 2=MUL).
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port req_valid_i, input, NUM_REQ: per-requester writeback request.
REQ-008 Port req_regno_i, input, NUM_REQ*LEN_REGNO: destination register per requester; requester i occupies slice i.
REQ-009 Port req_data_i, input, NUM_REQ*LEN_REG: result data per requester; requester i occupies slice i.
REQ-010 Port req_ready_o, input-side handshake output, NUM_REQ: one-hot grant; zero when nothing is granted.
REQ-011 Port issue_i, input, 1: decode reserves a destination this cycle.
REQ-012 Port issue_r_i, input, LEN_REGNO: register being reserved.
REQ-013 Port chk_r0_i / chk_r1_i, input, LEN_REGNO each: operand registers to hazard-check.
REQ-014 Port stall_o, output, 1: operand hazard.
REQ-015 Port wb_o, output, 1: register-file write enable.
REQ-016 Port wb_r_o, output, LEN_REGNO: register-file write register number.
REQ-017 Port result_o, output, LEN_REG: register-file write data.
REQ-018 Port pending_o, output, NUM_REGS: scoreboard bit per register.
REQ-019 Port err_o, output, 1: sticky protocol-error flag.

Function
REQ-020 A transfer from requester i occurs when req_valid_i[i] and req_ready_o[i] are both 1 at a rising edge.
REQ-021 req_ready_o is combinational from req_valid_i and the priority pointer; at most one bit is set.
REQ-022 Round-robin arbitration: the search starts at pointer p and grants the first valid requester in the order p, p+1, ... (mod NUM_REQ).
REQ-023 After a transfer from requester i, p becomes (i+1) mod NUM_REQ; with no transfer, p is unchanged.
REQ-024 Requesters hold valid, regno and data stable until their transfer; deasserting early is permitted and forfeits the grant without error.
REQ-025 Transfer data appears on wb_o=1, wb_r_o and result_o exactly 1 cycle after the transfer edge; wb_o=0 in any cycle with no transfer on the prior edge.
REQ-026 Throughput is one transfer per cycle; there are no idle cycles between back-to-back grants.
REQ-027 On a transfer to register r, pending[r] clears at the transfer edge.
REQ-028 On issue_i=1, pending[issue_r_i] sets at the edge.
REQ-029 If an issue and a transfer target the same register on the same edge, the set wins and pending stays 1.
REQ-030 stall_o = pending[chk_r0_i] | pending[chk_r1_i], combinational from the current pending bits.
REQ-031 err_o sets on a transfer to a register whose pending bit is 0.
REQ-032 err_o also sets on an issue to a register already pending, unless a transfer clears that register on the same edge.
REQ-033 err_o holds until reset.
REQ-034 Register 0 receives no special treatment.

Reset
REQ-035 While rst=1: p=0; pending_o=0; wb_o=0; wb_r_o=0; result_o=0; err_o=0.
REQ-036 While rst=1, req_ready_o is forced to 0, so no transfer can occur.
REQ-037 Reset asserted mid-transfer discards the in-flight writeback: wb_o drops to 0 immediately and asynchronously.

Configuration
REQ-038 Macro WBARB_FIXED_PRIO_EN selects the arbitration policy.
REQ-039 With WBARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; pointer logic is removed; REQ-022 and REQ-023 do not apply.
REQ-040 With WBARB_FIXED_PRIO_EN undefined: round-robin per REQ-022 and REQ-023.

Verification
REQ-041 Issue r5; MUL requests r5 with data 0xDEADBEEF -> req_ready_o=3'b100; next cycle wb_o=1, wb_r_o=5, result_o=0xDEADBEEF; pending[5]=0; err_o=0.
REQ-042 All three requesters valid for 6 cycles (round-robin) -> grant order 0,1,2,0,1,2; one wb_o pulse per cycle.
REQ-043 Same 6-cycle stimulus with WBARB_FIXED_PRIO_EN defined -> requester 0 granted every cycle; requesters 1 and 2 see ready=0.
REQ-044 Issue r3 and ALU transfer to r3 on the same edge -> pending[3] stays 1; err_o=0; chk_r0_i=3 gives stall_o=1.
REQ-045 ALU transfer to r7 with pending[7]=0 -> err_o=1, remaining 1 after 10 idle cycles.
REQ-046 Assert rst one cycle after a MEM transfer -> wb_o=0 and pending_o=0 immediately; after release, p=0 and err_o=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one result per cycle for the register file and keeps the per-register scoreboard.
// Define WBARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module writeback_arbiter #(
   parameter int LEN_REGNO = 4,
   parameter int LEN_REG   = 32,
   parameter int NUM_REGS  = 16,
   parameter int NUM_REQ   = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*LEN_REGNO-1:0] req_regno_i,
   input  logic [NUM_REQ*LEN_REG-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic                         issue_i,
   input  logic [LEN_REGNO-1:0]         issue_r_i,
   input  logic [LEN_REGNO-1:0]         chk_r0_i,
   input  logic [LEN_REGNO-1:0]         chk_r1_i,
   output logic                         stall_o,
   output logic                         wb_o,
   output logic [LEN_REGNO-1:0]         wb_r_o,
   output logic [LEN_REG-1:0]           result_o,
   output logic [NUM_REGS-1:0]          pending_o,
   output logic                         err_o
);

   logic [LEN_REGNO-1:0] regno_arr [NUM_REQ];
   logic [LEN_REG-1:0]   data_arr  [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign regno_arr[gi] = req_regno_i[gi*LEN_REGNO +: LEN_REGNO];
         assign data_arr[gi]  = req_data_i[gi*LEN_REG +: LEN_REG];
      end
   endgenerate

   logic [NUM_REQ-1:0]   grant;
   logic                 xfer;
   logic [LEN_REGNO-1:0] xfer_r;
   logic [LEN_REG-1:0]   xfer_data;

   logic                 wb_q;
   logic [LEN_REGNO-1:0] wb_r_q;
   logic [LEN_REG-1:0]   result_q;
   logic [NUM_REGS-1:0]  pending_q, pending_d;
   logic                 err_q, err_d;

`ifdef WBARB_FIXED_PRIO_EN
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid_i[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Search starts at the pointer and wraps modulo NUM_REQ.
   always_comb begin
      logic found;
      int   idx;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (req_valid_i[idx] && !found) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready_o[i]) begin
            ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign req_ready_o = rst ? '0 : grant;
   assign xfer        = |req_ready_o;

   always_comb begin
      xfer_r    = '0;
      xfer_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready_o[i]) begin
            xfer_r    = regno_arr[i];
            xfer_data = data_arr[i];
         end
      end
   end

   // Issue is applied after the clear so a same-edge reservation keeps the bit set.
   always_comb begin
      pending_d = pending_q;
      if (xfer) begin
         pending_d[xfer_r] = 1'b0;
      end
      if (issue_i) begin
         pending_d[issue_r_i] = 1'b1;
      end
      err_d = err_q
            | (xfer && !pending_q[xfer_r])
            | (issue_i && pending_q[issue_r_i] && !(xfer && (xfer_r == issue_r_i)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q      <= 1'b0;
         wb_r_q    <= '0;
         result_q  <= '0;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         wb_q      <= xfer;
         pending_q <= pending_d;
         err_q     <= err_d;
         if (xfer) begin
            wb_r_q   <= xfer_r;
            result_q <= xfer_data;
         end
      end
   end

   assign stall_o   = pending_q[chk_r0_i] | pending_q[chk_r1_i];
   assign wb_o      = wb_q;
   assign wb_r_o    = wb_r_q;
   assign result_o  = result_q;
   assign pending_o = pending_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-free behavioural scoreboard model.
module tb_writeback_arbiter;
   localparam int LR = 4;
   localparam int LD = 32;
   localparam int NR = 16;
   localparam int NQ = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NQ-1:0]    req_valid;
   logic [NQ*LR-1:0] req_regno;
   logic [NQ*LD-1:0] req_data;
   logic [NQ-1:0]    req_ready;
   logic             issue;
   logic [LR-1:0]    issue_r, chk_r0, chk_r1;
   logic             stall, wb;
   logic [LR-1:0]    wb_r;
   logic [LD-1:0]    result;
   logic [NR-1:0]    pending;
   logic             err;

   writeback_arbiter #(.LEN_REGNO(LR), .LEN_REG(LD), .NUM_REGS(NR), .NUM_REQ(NQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_regno_i(req_regno), .req_data_i(req_data),
      .req_ready_o(req_ready),
      .issue_i(issue), .issue_r_i(issue_r), .chk_r0_i(chk_r0), .chk_r1_i(chk_r1),
      .stall_o(stall), .wb_o(wb), .wb_r_o(wb_r), .result_o(result),
      .pending_o(pending), .err_o(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Reference model state
   int            m_ptr;
   bit [NR-1:0]   m_pend;
   bit            m_err;
   bit            m_wb;
   int            m_wbr;
   logic [LD-1:0] m_res;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int model_grant();
      int idx;
`ifdef WBARB_FIXED_PRIO_EN
      for (int i = 0; i < NQ; i++) if (req_valid[i]) return i;
`else
      for (int k = 0; k < NQ; k++) begin
         idx = (m_ptr + k) % NQ;
         if (req_valid[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_pend = '0; m_err = 0; m_wb = 0; m_wbr = 0; m_res = '0;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_regno = '0; req_data = '0;
      issue = 0; issue_r = '0; chk_r0 = '0; chk_r1 = '0;
   endtask

   task automatic set_req(input int i, input logic [LR-1:0] r, input logic [LD-1:0] d);
      req_valid[i] = 1'b1;
      req_regno[i*LR +: LR] = r;
      req_data[i*LD +: LD]  = d;
   endtask

   // One clock of the current inputs: combinational checks at negedge, state checks just after posedge.
   task automatic step(output logic [NQ-1:0] rdy_seen);
      int g, r;
      logic [NQ-1:0] er;
      @(negedge clk);
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      rdy_seen = req_ready;
      check("ready", req_ready, er);
      check("stall", stall, m_pend[chk_r0] | m_pend[chk_r1]);
      @(posedge clk);
      r = 0;
      if (g >= 0) r = int'(req_regno[g*LR +: LR]);
      if (issue && m_pend[issue_r] && !(g >= 0 && r == int'(issue_r))) m_err = 1;
      if (g >= 0) begin
         if (!m_pend[r]) m_err = 1;
         m_pend[r] = 0;
         m_ptr = (g + 1) % NQ;
         m_wb  = 1;
         m_wbr = r;
         m_res = req_data[g*LD +: LD];
      end else begin
         m_wb = 0;
      end
      if (issue) m_pend[issue_r] = 1;
      #1;
      n_txn++;
      $display("txn %0d grant=%0d wb=%0b wb_r=%0d pending=%04h err=%0b", n_txn, g, wb, wb_r, pending, err);
      check("wb", wb, m_wb);
      if (m_wb) begin
         check("wb_r", wb_r, m_wbr);
         check("result", result, m_res);
      end
      check("pending", pending, m_pend);
      check("err", err, m_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_wb", wb, 0);
      check("rst_wb_r", wb_r, 0);
      check("rst_result", result, 0);
      check("rst_pending", pending, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [NQ-1:0] rdy;
      logic [NQ-1:0] exp_rdy;
      model_reset();
      do_reset();

      // Issue r5, MUL writes it back
      issue = 1; issue_r = 5;
      step(rdy);
      issue = 0;
      set_req(2, 4'd5, 32'hDEADBEEF);
      step(rdy);
      check("r041_ready", rdy, 3'b100);
      check("r041_wb", wb, 1);
      check("r041_wb_r", wb_r, 5);
      check("r041_result", result, 32'hDEADBEEF);
      check("r041_pend5", pending[5], 0);
      check("r041_err", err, 0);
      clear_inputs();

      // Same-edge issue and writeback of r3
      issue = 1; issue_r = 3;
      step(rdy);
      set_req(0, 4'd3, 32'h1234_5678);
      step(rdy);
      clear_inputs();
      chk_r0 = 3;
      step(rdy);
      check("r044_pend3", pending[3], 1);
      check("r044_err", err, 0);
      check("r044_stall", stall, 1);
      clear_inputs();

      // Writeback to a non-pending register is a sticky error
      set_req(0, 4'd7, 32'h0000_0077);
      step(rdy);
      check("r045_err", err, 1);
      clear_inputs();
      for (int i = 0; i < 10; i++) step(rdy);
      check("r045_err_hold", err, 1);

      // All requesters valid for six cycles
      do_reset();
      for (int i = 0; i < NQ; i++) set_req(i, LR'(8 + i), $urandom);
      for (int k = 0; k < 6; k++) begin
         step(rdy);
`ifdef WBARB_FIXED_PRIO_EN
         exp_rdy = 3'b001;
`else
         exp_rdy = '0;
         exp_rdy[k % NQ] = 1'b1;
`endif
         check("r042_order", rdy, exp_rdy);
         check("r042_wb", wb, 1);
      end
      clear_inputs();

      // Reset right after a MEM transfer
      issue = 1; issue_r = 9;
      step(rdy);
      clear_inputs();
      set_req(1, 4'd9, 32'hCAFE_0009);
      step(rdy);
      check("r046_wb_before", wb, 1);
      req_valid = '1;
      rst = 1'b1;
      #1;
      check("r046_wb", wb, 0);
      check("r046_pending", pending, 0);
      check("r046_err", err, 0);
      check("r046_ready", req_ready, 0);
      @(posedge clk);
      #1;
      check("r046_ready_edge", req_ready, 0);
      check("r046_pending_edge", pending, 0);
      rst = 1'b0;
      model_reset();
      step(rdy);
      check("r046_ptr0", rdy, 3'b001);
      clear_inputs();

      // Randomized traffic on a small register window
      for (int n = 0; n < 400; n++) begin
         if (n % 60 == 59) do_reset();
         clear_inputs();
         for (int i = 0; i < NQ; i++)
            if ($urandom_range(0, 2) != 0) set_req(i, LR'($urandom_range(0, 5)), $urandom);
         issue   = ($urandom_range(0, 1) == 1);
         issue_r = LR'($urandom_range(0, 5));
         chk_r0  = LR'($urandom_range(0, 7));
         chk_r1  = LR'($urandom_range(0, 7));
         step(rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
